timer_array: RTL and testbench
==============================

Name: timer_array

Overview:
Parametrised multi-channel successor to the single Timer peripheral on the Bridge bus (Timer slot, CS==0).
- NUM_CH independent down-counters, each with:
  - its own prescaler;
  - a mode: one-shot, auto-reload or square-wave;
  - a maskable interrupt flag.
- The per-channel flags are ORed into one IRQ, which drives HWInt bit 10 of Pr_IP.
- Register access uses the Bridge's single-cycle word bus (We/ADDR/Din/Dout).

Parameters:
NUM_CH, 4, number of channels, legal range 1..8
WIDTH, 32, width of the counter and PRESET register
PS_WIDTH, 16, width of the prescaler and PRESCALE register

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
We  input  1  write strobe, already qualified by the Bridge chip-select
ADDR  input  32  byte address; ADDR[3:2]=register, ADDR[6:4]=channel
Din  input  32  write data
Dout  output  32  read data, combinational from ADDR
IRQ  output  1  OR over channels of (IFLAG & IM)
IRQ_VEC  output  NUM_CH  per-channel IFLAG & IM
WAVE  output  NUM_CH  per-channel square-wave output

Behaviour:
Register map, per channel c:
- reg 0 CTRL: [0]=EN, [2:1]=MODE, [3]=IM, [4]=IFLAG (write 1 clears it), other bits read 0.
- reg 1 PRESET: read/write, WIDTH bits.
- reg 2 COUNT: read-only; writes are ignored.
- reg 3 PRESCALE: read/write, PS_WIDTH bits.
- Reads from a channel index >= NUM_CH return 0. Narrow fields read zero-extended.

Reset (asynchronous):
- All registers, counters, prescalers, WAVE, IRQ and IRQ_VEC go to 0.
- Dout then reflects the zeroed registers.

Start:
- A CTRL write that raises EN from 0 to 1 loads COUNT<=PRESET and clears the prescaler, effective the next cycle.
- A CTRL write with EN=1 while EN is already 1 updates MODE and IM only. It does not reload COUNT.

Tick generation:
- While EN=1, the prescaler counts 0..PRESCALE.
- tick=1 in the cycle the prescaler equals PRESCALE; the prescaler then wraps to 0.
- PRESCALE=0 gives a tick every cycle.

On a tick:
- COUNT>1: COUNT<=COUNT-1.
- COUNT==1 (expiry): IFLAG<=1, then by mode:
  - MODE 0 (one-shot) and MODE 3: COUNT<=0, EN<=0.
  - MODE 1 (auto-reload): COUNT<=PRESET.
  - MODE 2 (square-wave): COUNT<=PRESET and WAVE[c] toggles.
- COUNT==0 with EN=1: MODE 0/3 clears EN and does not set IFLAG; MODE 1/2 holds at 0 and does not set IFLAG.

Register-update rules:
- A PRESET write during counting takes effect only at the next start or reload.
- A PRESCALE write takes effect immediately; the prescaler is not cleared.
- If an expiry and a write-1-to-clear of IFLAG happen in the same cycle, the set wins.
- A CTRL write with EN=0 stops counting. COUNT, the prescaler and WAVE hold their values.
- Latency: IFLAG and IRQ assert the cycle after the expiring tick edge. Dout is the same cycle as ADDR.

Optional Feature:
Macro TIMER_GLOBAL_STATUS_EN.
- Defined: channel index NUM_CH, reg 0 is a global status register. Reads return IFLAG[NUM_CH-1:0] zero-extended. Writing 1s clears the matching IFLAGs, with the same set-wins rule.
- Not defined: that address reads 0 and writes are ignored.

Test Plan:
1. Reset mid-count: assert reset while ch0 COUNT=5 -> all registers, WAVE and IRQ read 0 immediately, before the next clk edge.
2. One-shot: ch0 PRESET=3, PRESCALE=0, CTRL=0x9 (EN, mode 0, IM) -> COUNT reads 3,2,1,0; IRQ rises the cycle after COUNT leaves 1; EN reads 0. Write CTRL=0x10 -> IRQ falls the next cycle.
3. Auto-reload with prescaler: ch1 PRESET=2, PRESCALE=1, MODE=1, IM=1 -> expiry every 4 clk cycles. COUNT sequence is 2,2,1,1,2,2,...; IRQ_VEC[1]=1 after the first expiry.
4. Square-wave: ch2 PRESET=4, PRESCALE=0, MODE=2, IM=0 -> WAVE[2] toggles every 4 cycles; IRQ stays 0 while CTRL reads IFLAG=1.
5. Simultaneous clear and expiry: write CTRL with bit4=1 in the exact cycle ch0 expires -> IFLAG remains 1. PRESET write of 7 during counting -> the current count is unaffected and the next reload loads 7.
6. With TIMER_GLOBAL_STATUS_EN: ch0 and ch3 expired -> global status reads 0x9; write 0x1 -> reads 0x8. Without the macro -> reads 0.

Source files
------------

// File: rtl/timer_array_if.sv
// timer_array_if: single-cycle word bus between the Bridge and the timer array.
interface timer_array_if;
    logic        We;
    logic [31:0] ADDR;
    logic [31:0] Din;
    logic [31:0] Dout;
    modport master (output We, ADDR, Din, input Dout);
    modport slave (input We, ADDR, Din, output Dout);
endinterface

// File: rtl/timer_array.sv
// timer_array: NUM_CH prescaled down-counters (one-shot/auto-reload/square-wave) with maskable IRQs.
// Optional TIMER_GLOBAL_STATUS_EN adds a global IFLAG status/clear register at channel index NUM_CH.
module timer_array #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int PS_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    timer_array_if.slave      bus,
    output logic              IRQ,
    output logic [NUM_CH-1:0] IRQ_VEC,
    output logic [NUM_CH-1:0] WAVE
);
    logic [NUM_CH-1:0]   en, im, iflag, wave, wsel, stop, act, tick, expire, gclr;
    logic [1:0]          mode     [NUM_CH];
    logic [WIDTH-1:0]    preset   [NUM_CH];
    logic [WIDTH-1:0]    count    [NUM_CH];
    logic [PS_WIDTH-1:0] prescale [NUM_CH];
    logic [PS_WIDTH-1:0] ps       [NUM_CH];
    logic [2:0]          ch;
    logic [1:0]          sel;
    logic                unused;
    assign ch      = bus.ADDR[6:4];
    assign sel     = bus.ADDR[3:2];
    assign unused  = ^{bus.ADDR[31:7], bus.ADDR[1:0], bus.Din};
    assign IRQ_VEC = iflag & im;
    assign IRQ     = |IRQ_VEC;
    assign WAVE    = wave;
`ifdef TIMER_GLOBAL_STATUS_EN
    assign gclr = (bus.We && {1'b0, ch} == 4'(NUM_CH) && sel == 2'd0) ? bus.Din[NUM_CH-1:0] : '0;
`else
    assign gclr = '0;
`endif
    // A CTRL write with EN=0 freezes the channel in the same cycle, so it also masks that cycle's tick.
    always_comb begin
        wsel   = '0;
        stop   = '0;
        act    = '0;
        tick   = '0;
        expire = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wsel[c]   = bus.We && ch == 3'(c);
            stop[c]   = wsel[c] && sel == 2'd0 && !bus.Din[0];
            act[c]    = en[c] && !stop[c];
            tick[c]   = act[c] && ps[c] == prescale[c];
            expire[c] = tick[c] && count[c] == WIDTH'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en    <= '0;
            im    <= '0;
            iflag <= '0;
            wave  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode[c]     <= '0;
                preset[c]   <= '0;
                count[c]    <= '0;
                prescale[c] <= '0;
                ps[c]       <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (act[c]) ps[c] <= tick[c] ? '0 : ps[c] + PS_WIDTH'(1);
                if (tick[c]) begin
                    if (count[c] > WIDTH'(1)) count[c] <= count[c] - WIDTH'(1);
                    else if (expire[c]) begin
                        count[c] <= ^mode[c] ? preset[c] : '0;
                        if (!(^mode[c])) en[c] <= 1'b0;
                        if (mode[c] == 2'd2) wave[c] <= ~wave[c];
                    end else if (!(^mode[c])) en[c] <= 1'b0;
                end
                // Clear first, then set, so an expiry in the same cycle wins.
                if ((wsel[c] && sel == 2'd0 && bus.Din[4]) || gclr[c]) iflag[c] <= 1'b0;
                if (expire[c]) iflag[c] <= 1'b1;
                if (wsel[c] && sel == 2'd0) begin
                    mode[c] <= bus.Din[2:1];
                    im[c]   <= bus.Din[3];
                    if (!bus.Din[0]) en[c] <= 1'b0;
                    else if (!en[c]) begin
                        en[c]    <= 1'b1;
                        count[c] <= preset[c];
                        ps[c]    <= '0;
                    end
                end
                if (wsel[c] && sel == 2'd1) preset[c] <= bus.Din[WIDTH-1:0];
                if (wsel[c] && sel == 2'd3) prescale[c] <= bus.Din[PS_WIDTH-1:0];
            end
        end
    end
    always_comb begin
        bus.Dout = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch == 3'(c))
                bus.Dout = sel == 2'd0 ? {27'b0, iflag[c], im[c], mode[c], en[c]} :
                           sel == 2'd1 ? 32'(preset[c]) :
                           sel == 2'd2 ? 32'(count[c]) : 32'(prescale[c]);
`ifdef TIMER_GLOBAL_STATUS_EN
        if ({1'b0, ch} == 4'(NUM_CH) && sel == 2'd0) bus.Dout = 32'(iflag);
`endif
    end
endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: directed self-checking bench for timer_array (4 channels, default widths).
module tb_timer_array;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       IRQ;
    logic [3:0] IRQ_VEC, WAVE;
    int         checks = 0;
    int         errors = 0;
    timer_array_if bus();
    timer_array #(.NUM_CH(4), .WIDTH(32), .PS_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .IRQ(IRQ), .IRQ_VEC(IRQ_VEC), .WAVE(WAVE)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // Reads are taken 1 time unit after a falling edge, well clear of the rising edge.
    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.ADDR = a;
        #1;
        chk(tag, bus.Dout, exp);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.We   = 1'b1;
        bus.ADDR = a;
        bus.Din  = d;
        @(negedge clk);
        bus.We   = 1'b0;
    endtask
    int exp3 [9] = '{2, 2, 1, 1, 2, 2, 1, 1, 2};
    int exp5 [4] = '{2, 1, 7, 6};
    initial begin
        bus.We = 1'b0;
        bus.ADDR = '0;
        bus.Din = '0;
        @(negedge clk);
        chk_rd("por_ctrl", 32'h00, 0);
        chk("por_irq", {31'b0, IRQ}, 0);
        reset = 1'b0;
        // Reset mid-count
        wr(32'h04, 10);
        wr(32'h00, 32'h1);
        repeat (5) @(negedge clk);
        chk_rd("pre_reset_count", 32'h08, 5);
        reset = 1'b1;
        chk_rd("rst_count", 32'h08, 0);
        chk_rd("rst_ctrl", 32'h00, 0);
        chk_rd("rst_preset", 32'h04, 0);
        chk("rst_wave_irq", {27'b0, IRQ, WAVE}, 0);
        @(negedge clk);
        reset = 1'b0;
        // One-shot
        wr(32'h04, 3);
        wr(32'h00, 32'h9);
        for (int i = 0; i < 3; i++) begin
            chk_rd($sformatf("os_count%0d", i), 32'h08, 32'(3 - i));
            chk($sformatf("os_irq%0d", i), {31'b0, IRQ}, 0);
            @(negedge clk);
        end
        chk_rd("os_count_end", 32'h08, 0);
        chk("os_irq_set", {31'b0, IRQ}, 1);
        chk_rd("os_ctrl", 32'h00, 32'h18);
        @(negedge clk);
        chk_rd("os_count_hold", 32'h08, 0);
        wr(32'h00, 32'h10);
        chk("os_irq_clr", {31'b0, IRQ}, 0);
        chk_rd("os_ctrl_clr", 32'h00, 32'h00);
        // Auto-reload with prescaler
        wr(32'h14, 2);
        wr(32'h1C, 1);
        wr(32'h10, 32'hB);
        for (int i = 0; i < 9; i++) begin
            chk_rd($sformatf("ar_count%0d", i), 32'h18, 32'(exp3[i]));
            if (i == 3) chk("ar_vec_before", {28'b0, IRQ_VEC}, 0);
            if (i == 4) chk("ar_vec_after", {28'b0, IRQ_VEC}, 32'h2);
            @(negedge clk);
        end
        wr(32'h10, 32'h10);
        chk_rd("ar_stop_count", 32'h18, 2);
        @(negedge clk);
        chk_rd("ar_stop_hold", 32'h18, 2);
        // Square-wave
        wr(32'h24, 4);
        wr(32'h20, 32'h5);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("sq_wave%0d", i), {28'b0, WAVE}, (i >= 4 && i < 8) ? 32'h4 : 32'h0);
            @(negedge clk);
        end
        chk_rd("sq_ctrl", 32'h20, 32'h15);
        chk("sq_irq", {31'b0, IRQ}, 0);
        wr(32'h20, 32'h0);
        // Clear and expiry in the same cycle
        wr(32'h00, 32'h9);
        chk_rd("sc_count0", 32'h08, 3);
        @(negedge clk);
        chk_rd("sc_count1", 32'h08, 2);
        @(negedge clk);
        chk_rd("sc_count2", 32'h08, 1);
        wr(32'h00, 32'h19);
        chk_rd("sc_ctrl", 32'h00, 32'h18);
        chk("sc_irq", {31'b0, IRQ}, 1);
        // PRESET write during counting
        wr(32'h1C, 0);
        wr(32'h14, 4);
        wr(32'h10, 32'hB);
        chk_rd("pw_count0", 32'h18, 4);
        wr(32'h14, 7);
        chk_rd("pw_count1", 32'h18, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_rd($sformatf("pw_seq%0d", i), 32'h18, 32'(exp5[i]));
        end
        wr(32'h10, 32'h10);
        wr(32'h18, 32'h55);
        chk_rd("count_ro", 32'h18, 6);
        chk("vec_mix", {28'b0, IRQ_VEC}, 32'h1);
        // Global status
        wr(32'h20, 32'h10);
        wr(32'h34, 1);
        wr(32'h30, 32'h1);
        @(negedge clk);
        chk_rd("gs_ch3_ctrl", 32'h30, 32'h10);
`ifdef TIMER_GLOBAL_STATUS_EN
        chk_rd("gs_read", 32'h40, 32'h9);
        wr(32'h40, 32'h1);
        chk_rd("gs_read_clr", 32'h40, 32'h8);
        chk_rd("gs_ch0_ctrl", 32'h00, 32'h08);
`else
        chk_rd("gs_read", 32'h40, 0);
        wr(32'h40, 32'h1);
        chk_rd("gs_read_wr", 32'h40, 0);
        chk_rd("gs_ch0_ctrl", 32'h00, 32'h18);
`endif
        chk_rd("oor_ch5", 32'h54, 0);
        wr(32'h3C, 32'hFFFF_FFFF);
        chk_rd("ps_narrow", 32'h3C, 32'h0000_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
